ats21_cmd_arbiter: RTL and testbench
====================================

ATS21_CMD_ARBITER -- requirements
Module: ats21_cmd_arbiter

Interface
REQ-001 Parameter STAT_LAT, default 2: number of WAIT cycles between low-half issue and stat sampling, legal range 1-7.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_valid / b_valid  input  1  requester A/B command valid.
REQ-005 a_cmd / b_cmd  input  32  requester command, opcode [31:29], ATS21 instruction format.
REQ-006 a_ready / b_ready  output  1  holding register empty; command accepted on valid&ready.
REQ-007 a_rsp_valid / b_rsp_valid  output  1  one-cycle completion pulse.
REQ-008 a_rsp_ok / b_rsp_ok  output  1  1=Ack, 0=Nack; meaningful only with the matching rsp_valid.
REQ-009 req  output  1  ATS21 request strobe.
REQ-010 ctrlA / ctrlB  output  16  ATS21 lane A/B instruction halves.
REQ-011 stat  input  2  ATS21 status, [0]=lane A, [1]=lane B.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL hold one command per requester; x_ready SHALL be ~held_x.
REQ-014 FSM states SHALL be IDLE, HI, LO, WAIT, RESP.
REQ-015 IDLE -> HI when any held command exists and the same cycle selects the issue set; otherwise remain IDLE.
REQ-016 Held opcode 000 SHALL never be issued: in IDLE it SHALL produce rsp_valid=1, rsp_ok=1 the next cycle and release the hold, with no bus activity.
REQ-017 Conflict: both held and non-000, and either both clock-class (001/010) with equal [28:25], or both alarm-class (101/110/111) with equal [28:24], or both 011.
REQ-018 No conflict: both commands SHALL issue together, A on ctrlA, B on ctrlB.
REQ-019 Conflict: only the priority winner SHALL issue; the loser stays held; priority SHALL toggle after each conflicted round; reset priority = A.
REQ-020 HI: req=1, ctrlx = cmd[31:16] for issued lanes, 16'h0000 for idle lanes.
REQ-021 LO: req=0, ctrlx = cmd[15:0] for issued lanes, 16'h0000 for idle lanes.
REQ-022 WAIT SHALL last exactly STAT_LAT cycles with req=0, ctrlA=ctrlB=0; stat is sampled in the last WAIT cycle.
REQ-023 RESP: rsp_valid=1 for issued lanes only, rsp_ok = sampled stat bit, holds released; next state IDLE.
REQ-024 Latency, single command accepted in cycle T: HI at T+2, LO at T+3, rsp_valid at T+4+STAT_LAT.
REQ-025 A command arriving while busy SHALL be accepted if its holding register is empty and SHALL wait for the next IDLE.
REQ-026 Outside HI, req SHALL be 0; outside HI/LO, ctrlA=ctrlB=16'h0000.

Reset
REQ-027 While reset=1: state=IDLE, holds cleared, priority=A, req=0, ctrlA=ctrlB=0, rsp_valid=0, rsp_ok=0, busy=0, a_ready=b_ready=0.
REQ-028 Reset mid-transaction SHALL abort without any rsp pulse; a_ready=b_ready=1 in the first cycle after reset deasserts.

Verification
REQ-029 A only, a_cmd=32'h2080_0005 (set clock 0, rate 10, count 5), stat=2'b01 -> req high 1 cycle, ctrlA=16'h2080 then 16'h0005, ctrlB=0, a_rsp_ok=1 at T+6 with STAT_LAT=2.
REQ-030 A=32'hA100_0010 (alarm 1), B=32'hA200_0020 (alarm 2) same cycle -> one joint issue, both rsp pulses same cycle.
REQ-031 A and B both 32'hA100_xxxx (alarm 1) -> A issued first, B issued next round, next conflict B wins.
REQ-032 a_cmd=0 -> a_rsp_valid=1, a_rsp_ok=1 one cycle after IDLE sees it, req never asserts.
REQ-033 stat=2'b10 with joint issue -> a_rsp_ok=0, b_rsp_ok=1.
REQ-034 reset asserted during WAIT -> no rsp pulses, req=0, busy=0, both ready=1 after release.

Source files
------------

// File: rtl/ats21_cmd_arbiter_if.sv
// Requester handshake and ATS21 bus signals for the two-requester command arbiter.
// The master side drives commands and status; the slave side is the arbiter itself.
interface ats21_cmd_arbiter_if;
    logic        a_valid;
    logic [31:0] a_cmd;
    logic        a_ready;
    logic        a_rsp_valid;
    logic        a_rsp_ok;
    logic        b_valid;
    logic [31:0] b_cmd;
    logic        b_ready;
    logic        b_rsp_valid;
    logic        b_rsp_ok;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic [1:0]  stat;
    logic        busy;

    modport master (
        output a_valid, a_cmd, b_valid, b_cmd, stat,
        input  a_ready, a_rsp_valid, a_rsp_ok, b_ready, b_rsp_valid, b_rsp_ok,
        input  req, ctrlA, ctrlB, busy
    );

    modport slave (
        input  a_valid, a_cmd, b_valid, b_cmd, stat,
        output a_ready, a_rsp_valid, a_rsp_ok, b_ready, b_rsp_valid, b_rsp_ok,
        output req, ctrlA, ctrlB, busy
    );
endinterface

// File: rtl/ats21_cmd_arbiter.sv
// Two-requester ATS21 command arbiter: holds one command per requester, issues
// non-conflicting commands jointly as HI/LO halves and reports Ack/Nack from stat.
module ats21_cmd_arbiter #(
    parameter int STAT_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    ats21_cmd_arbiter_if.slave bus
);

    localparam logic [2:0] LAST_WAIT = 3'(STAT_LAT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    // Two commands collide when they address the same clock, the same alarm, or are both 011.
    function automatic logic f_clash(input logic [31:0] ca, input logic [31:0] cb);
        logic [2:0] oa;
        logic [2:0] ob;
        logic       clk_a;
        logic       clk_b;
        logic       alm_a;
        logic       alm_b;
        oa    = ca[31:29];
        ob    = cb[31:29];
        clk_a = (oa == 3'b001) || (oa == 3'b010);
        clk_b = (ob == 3'b001) || (ob == 3'b010);
        alm_a = (oa == 3'b101) || (oa == 3'b110) || (oa == 3'b111);
        alm_b = (ob == 3'b101) || (ob == 3'b110) || (ob == 3'b111);
        f_clash = (clk_a && clk_b && (ca[28:25] == cb[28:25])) ||
                  (alm_a && alm_b && (ca[28:24] == cb[28:24])) ||
                  ((oa == 3'b011) && (ob == 3'b011));
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        r_held_a, r_held_b;
    logic [31:0] r_cmd_a, r_cmd_b;
    logic        r_iss_a, r_iss_b;
    logic        r_prio_b;
    logic [2:0]  r_wait_cnt;
    logic        r_req;
    logic [15:0] r_ctrl_a, r_ctrl_b;
    logic        r_a_rsp_valid, r_a_rsp_ok, r_b_rsp_valid, r_b_rsp_ok;

    logic        w_a_ready, w_b_ready;
    logic        w_nop_a, w_nop_b, w_live_a, w_live_b;
    logic        w_conflict, w_sel_a, w_sel_b;
    logic        w_idle, w_wait_done;
    logic        w_iss_a, w_iss_b, w_rel_a, w_rel_b;
    logic        w_req_nxt;
    logic [15:0] w_ctrl_a_nxt, w_ctrl_b_nxt;
    logic        w_a_rsp_v_nxt, w_a_rsp_ok_nxt, w_b_rsp_v_nxt, w_b_rsp_ok_nxt;

    assign w_a_ready   = ~r_held_a & ~reset;
    assign w_b_ready   = ~r_held_b & ~reset;
    assign w_nop_a     = r_held_a & (r_cmd_a[31:29] == 3'b000);
    assign w_nop_b     = r_held_b & (r_cmd_b[31:29] == 3'b000);
    assign w_live_a    = r_held_a & ~w_nop_a;
    assign w_live_b    = r_held_b & ~w_nop_b;
    assign w_conflict  = w_live_a & w_live_b & f_clash(r_cmd_a, r_cmd_b);
    assign w_sel_a     = w_live_a & (~w_conflict | ~r_prio_b);
    assign w_sel_b     = w_live_b & (~w_conflict | r_prio_b);
    assign w_idle      = (r_state == IDLE);
    assign w_wait_done = (r_state == WAIT) && (r_wait_cnt == LAST_WAIT);

    // Next-state, issue set and hold-release decode.
    always_comb begin
        w_next  = r_state;
        w_iss_a = r_iss_a;
        w_iss_b = r_iss_b;
        w_rel_a = 1'b0;
        w_rel_b = 1'b0;
        case (r_state)
            IDLE: begin
                w_iss_a = w_sel_a;
                w_iss_b = w_sel_b;
                w_rel_a = w_nop_a;
                w_rel_b = w_nop_b;
                if (w_sel_a || w_sel_b) begin
                    w_next = HI;
                end else begin
                    w_next = IDLE;
                end
            end
            HI:   w_next = LO;
            LO:   w_next = WAIT;
            WAIT: begin
                if (w_wait_done) begin
                    w_next = RESP;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP: begin
                w_rel_a = r_iss_a;
                w_rel_b = r_iss_b;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Bus and response values for the coming cycle, so every output leaves a flop.
    always_comb begin
        w_req_nxt    = (w_next == HI);
        w_ctrl_a_nxt = 16'h0000;
        w_ctrl_b_nxt = 16'h0000;
        case (w_next)
            HI: begin
                w_ctrl_a_nxt = w_iss_a ? r_cmd_a[31:16] : 16'h0000;
                w_ctrl_b_nxt = w_iss_b ? r_cmd_b[31:16] : 16'h0000;
            end
            LO: begin
                w_ctrl_a_nxt = w_iss_a ? r_cmd_a[15:0] : 16'h0000;
                w_ctrl_b_nxt = w_iss_b ? r_cmd_b[15:0] : 16'h0000;
            end
            default: begin
                w_ctrl_a_nxt = 16'h0000;
                w_ctrl_b_nxt = 16'h0000;
            end
        endcase
        // stat is sampled on the edge that closes the last WAIT cycle.
        w_a_rsp_v_nxt  = (w_wait_done & r_iss_a) | (w_idle & w_nop_a);
        w_b_rsp_v_nxt  = (w_wait_done & r_iss_b) | (w_idle & w_nop_b);
        w_a_rsp_ok_nxt = (w_wait_done & r_iss_a & bus.stat[0]) | (w_idle & w_nop_a);
        w_b_rsp_ok_nxt = (w_wait_done & r_iss_b & bus.stat[1]) | (w_idle & w_nop_b);
    end

    // State, holding registers, priority and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_held_a      <= 1'b0;
            r_held_b      <= 1'b0;
            r_cmd_a       <= 32'h0000_0000;
            r_cmd_b       <= 32'h0000_0000;
            r_iss_a       <= 1'b0;
            r_iss_b       <= 1'b0;
            r_prio_b      <= 1'b0;
            r_wait_cnt    <= 3'd0;
            r_req         <= 1'b0;
            r_ctrl_a      <= 16'h0000;
            r_ctrl_b      <= 16'h0000;
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_ok    <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_ok    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_held_a <= (r_held_a & ~w_rel_a) | (bus.a_valid & w_a_ready);
            r_held_b <= (r_held_b & ~w_rel_b) | (bus.b_valid & w_b_ready);
            if (bus.a_valid && w_a_ready) begin
                r_cmd_a <= bus.a_cmd;
            end
            if (bus.b_valid && w_b_ready) begin
                r_cmd_b <= bus.b_cmd;
            end
            r_iss_a       <= w_iss_a;
            r_iss_b       <= w_iss_b;
            r_prio_b      <= r_prio_b ^ (w_idle & w_conflict);
            r_wait_cnt    <= (r_state == WAIT) ? (r_wait_cnt + 3'd1) : 3'd0;
            r_req         <= w_req_nxt;
            r_ctrl_a      <= w_ctrl_a_nxt;
            r_ctrl_b      <= w_ctrl_b_nxt;
            r_a_rsp_valid <= w_a_rsp_v_nxt;
            r_a_rsp_ok    <= w_a_rsp_ok_nxt;
            r_b_rsp_valid <= w_b_rsp_v_nxt;
            r_b_rsp_ok    <= w_b_rsp_ok_nxt;
        end
    end

    // Outputs are forced quiet for as long as reset is held.
    assign bus.a_ready     = w_a_ready;
    assign bus.b_ready     = w_b_ready;
    assign bus.req         = r_req & ~reset;
    assign bus.ctrlA       = r_ctrl_a & {16{~reset}};
    assign bus.ctrlB       = r_ctrl_b & {16{~reset}};
    assign bus.a_rsp_valid = r_a_rsp_valid & ~reset;
    assign bus.a_rsp_ok    = r_a_rsp_ok & ~reset;
    assign bus.b_rsp_valid = r_b_rsp_valid & ~reset;
    assign bus.b_rsp_ok    = r_b_rsp_ok & ~reset;
    assign bus.busy        = (r_state != IDLE) & ~reset;

endmodule

// File: tb/tb_ats21_cmd_arbiter.sv
// Scoreboard bench for ats21_cmd_arbiter: a schedule-based reference model predicts
// bus activity and responses per cycle; a monitor compares the DUT every cycle.
module tb_ats21_cmd_arbiter;

    localparam int L     = 2;
    localparam int NEVER = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ats21_cmd_arbiter_if bus_if();
    ats21_cmd_arbiter #(.STAT_LAT(L)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_pass = 0;
    bit   chk_en = 1'b0;
    bit   use_force = 1'b0;
    logic [1:0] stat_force = 2'b00;

    typedef struct {
        int   cyc;
        int   samp;
        logic ok;
    } rsp_t;
    rsp_t q_a[$];
    rsp_t q_b[$];

    logic        exp_ready_a[int];
    logic        exp_ready_b[int];
    logic        exp_req[int];
    logic        exp_busy[int];
    logic [15:0] exp_ca[int];
    logic [15:0] exp_cb[int];

    bit          m_held_a, m_held_b, m_prio_b;
    logic [31:0] m_cmd_a, m_cmd_b;
    int          m_rel_a, m_rel_b, m_free;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Class 1 = clock, 2 = alarm, 3 = opcode 011, 0 = never conflicts.
    function automatic int cls(input logic [31:0] c);
        case (c[31:29])
            3'b001, 3'b010:         return 1;
            3'b101, 3'b110, 3'b111: return 2;
            3'b011:                 return 3;
            default:                return 0;
        endcase
    endfunction

    function automatic int key(input logic [31:0] c);
        if (cls(c) == 1) return int'(c[28:25]);
        if (cls(c) == 2) return int'(c[28:24]);
        return 0;
    endfunction

    function automatic bit clash(input logic [31:0] a, input logic [31:0] b);
        return (cls(a) != 0) && (cls(a) == cls(b)) && (key(a) == key(b));
    endfunction

    task automatic model_reset();
        q_a.delete(); q_b.delete();
        exp_ready_a.delete(); exp_ready_b.delete();
        exp_req.delete(); exp_busy.delete(); exp_ca.delete(); exp_cb.delete();
        m_held_a = 1'b0; m_held_b = 1'b0; m_prio_b = 1'b0;
        m_cmd_a = 32'h0; m_cmd_b = 32'h0;
        m_rel_a = NEVER; m_rel_b = NEVER; m_free = 0;
    endtask

    // Advance the model over cycle n using the inputs now on the bus.
    task automatic model_step();
        int n;
        bit acc_a, acc_b, nop_a, nop_b, live_a, live_b, cf, go_a, go_b;
        n = cyc;
        foreach (q_a[i]) if (q_a[i].samp == n) q_a[i].ok = bus_if.stat[0];
        foreach (q_b[i]) if (q_b[i].samp == n) q_b[i].ok = bus_if.stat[1];
        acc_a = bus_if.a_valid && !m_held_a;
        acc_b = bus_if.b_valid && !m_held_b;
        if (n >= m_free) begin
            nop_a  = m_held_a && (m_cmd_a[31:29] == 3'b000);
            nop_b  = m_held_b && (m_cmd_b[31:29] == 3'b000);
            live_a = m_held_a && !nop_a;
            live_b = m_held_b && !nop_b;
            if (nop_a) begin q_a.push_back('{n + 1, -1, 1'b1}); m_rel_a = n + 1; end
            if (nop_b) begin q_b.push_back('{n + 1, -1, 1'b1}); m_rel_b = n + 1; end
            cf   = live_a && live_b && clash(m_cmd_a, m_cmd_b);
            go_a = live_a && (!cf || !m_prio_b);
            go_b = live_b && (!cf || m_prio_b);
            if (cf) m_prio_b = !m_prio_b;
            if (go_a || go_b) begin
                exp_req[n + 1] = 1'b1;
                exp_ca[n + 1] = go_a ? m_cmd_a[31:16] : 16'h0000;
                exp_cb[n + 1] = go_b ? m_cmd_b[31:16] : 16'h0000;
                exp_ca[n + 2] = go_a ? m_cmd_a[15:0] : 16'h0000;
                exp_cb[n + 2] = go_b ? m_cmd_b[15:0] : 16'h0000;
                for (int k = n + 1; k <= n + 3 + L; k++) exp_busy[k] = 1'b1;
                if (go_a) begin q_a.push_back('{n + 3 + L, n + 2 + L, 1'bx}); m_rel_a = n + 4 + L; end
                if (go_b) begin q_b.push_back('{n + 3 + L, n + 2 + L, 1'bx}); m_rel_b = n + 4 + L; end
                m_free = n + 4 + L;
            end
        end
        if (acc_a) begin
            m_held_a = 1'b1; m_cmd_a = bus_if.a_cmd; m_rel_a = NEVER;
        end else if (m_held_a && m_rel_a == n + 1) begin
            m_held_a = 1'b0;
        end
        if (acc_b) begin
            m_held_b = 1'b1; m_cmd_b = bus_if.b_cmd; m_rel_b = NEVER;
        end else if (m_held_b && m_rel_b == n + 1) begin
            m_held_b = 1'b0;
        end
        exp_ready_a[n + 1] = !m_held_a;
        exp_ready_b[n + 1] = !m_held_b;
    endtask

    task automatic drive(input bit av, input logic [31:0] ac, input bit bv, input logic [31:0] bc);
        @(negedge clk);
        bus_if.a_valid = av;
        bus_if.a_cmd   = ac;
        bus_if.b_valid = bv;
        bus_if.b_cmd   = bc;
        bus_if.stat    = use_force ? stat_force : 2'($urandom_range(0, 3));
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        chk_en = 1'b0;
        reset = 1'b1;
        bus_if.a_valid = 1'b0;
        bus_if.b_valid = 1'b0;
        #1;
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_req", 32'(bus_if.req), 32'd0);
        chk("rst_ready", 32'({bus_if.a_ready, bus_if.b_ready}), 32'd0);
        repeat (ncyc) @(negedge clk);
        reset = 1'b0;
        model_reset();
        model_step();
        chk_en = 1'b1;
        #1;
        chk("post_rst_ready", 32'({bus_if.a_ready, bus_if.b_ready}), 32'd3);
        chk("post_rst_busy", 32'(bus_if.busy), 32'd0);
        chk("post_rst_req", 32'(bus_if.req), 32'd0);
    endtask

    function automatic logic [31:0] rnd_cmd();
        logic [31:0] c;
        c = $urandom;
        c[31:29] = 3'($urandom_range(0, 7));
        c[28:24] = 5'($urandom_range(0, 3));
        return c;
    endfunction

    // Monitor: compares every output each cycle and pops the scoreboard on responses.
    always begin
        int c;
        rsp_t e;
        @(posedge clk);
        #1;
        c = cyc;
        if (reset) begin
            chk("rst_rsp_valid", 32'({bus_if.a_rsp_valid, bus_if.b_rsp_valid}), 32'd0);
            chk("rst_ctrl", {bus_if.ctrlA, bus_if.ctrlB}, 32'd0);
            chk("rst_busy_mon", 32'(bus_if.busy), 32'd0);
        end else if (chk_en) begin
            chk("a_ready", 32'(bus_if.a_ready), 32'(exp_ready_a.exists(c) ? exp_ready_a[c] : 1'b1));
            chk("b_ready", 32'(bus_if.b_ready), 32'(exp_ready_b.exists(c) ? exp_ready_b[c] : 1'b1));
            chk("req", 32'(bus_if.req), 32'(exp_req.exists(c) ? exp_req[c] : 1'b0));
            chk("busy", 32'(bus_if.busy), 32'(exp_busy.exists(c) ? exp_busy[c] : 1'b0));
            chk("ctrlA", 32'(bus_if.ctrlA), 32'(exp_ca.exists(c) ? exp_ca[c] : 16'h0000));
            chk("ctrlB", 32'(bus_if.ctrlB), 32'(exp_cb.exists(c) ? exp_cb[c] : 16'h0000));
            if (bus_if.a_rsp_valid) begin
                chk("a_rsp_expected", 32'(q_a.size() != 0), 32'd1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    chk("a_rsp_cycle", 32'(c), 32'(e.cyc));
                    chk("a_rsp_ok", 32'(bus_if.a_rsp_ok), 32'(e.ok));
                end
            end else if (q_a.size() != 0 && q_a[0].cyc <= c) begin
                chk("a_rsp_missing", 32'(bus_if.a_rsp_valid), 32'd1);
                void'(q_a.pop_front());
            end
            if (bus_if.b_rsp_valid) begin
                chk("b_rsp_expected", 32'(q_b.size() != 0), 32'd1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    chk("b_rsp_cycle", 32'(c), 32'(e.cyc));
                    chk("b_rsp_ok", 32'(bus_if.b_rsp_ok), 32'(e.ok));
                end
            end else if (q_b.size() != 0 && q_b[0].cyc <= c) begin
                chk("b_rsp_missing", 32'(bus_if.b_rsp_valid), 32'd1);
                void'(q_b.pop_front());
            end
        end
    end

    initial begin
        bus_if.a_valid = 1'b0;
        bus_if.b_valid = 1'b0;
        bus_if.a_cmd   = 32'h0;
        bus_if.b_cmd   = 32'h0;
        bus_if.stat    = 2'b00;
        do_reset(3);

        use_force = 1'b1;
        stat_force = 2'b01;
        drive(1'b1, 32'h2080_0005, 1'b0, 32'h0);
        idle(10);

        stat_force = 2'b10;
        drive(1'b1, 32'hA100_0010, 1'b1, 32'hA200_0020);
        idle(10);

        stat_force = 2'b11;
        drive(1'b1, 32'hA100_1111, 1'b1, 32'hA100_2222);
        idle(16);
        drive(1'b1, 32'hA100_3333, 1'b1, 32'hA100_4444);
        idle(16);

        drive(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        idle(4);

        drive(1'b1, 32'h2080_0005, 1'b0, 32'h0);
        idle(3);
        do_reset(2);
        idle(4);

        use_force = 1'b0;
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 3) == 0), rnd_cmd(), ($urandom_range(0, 3) == 0), rnd_cmd());
        end
        idle(24);
        chk_en = 1'b0;
        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
